// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, state encoding and instruction field helpers
// Used by proc_sequencer; fields: op=ir[15:12], reg_a=ir[11:9], reg_b=ir[8:6], imm=ir[7:0].
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  function automatic logic [3:0] f_op(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [2:0] f_reg_a(input logic [15:0] instr);
    return instr[11:9];
  endfunction

  function automatic logic [2:0] f_reg_b(input logic [15:0] instr);
    return instr[8:6];
  endfunction

  function automatic logic [7:0] f_imm(input logic [15:0] instr);
    return instr[7:0];
  endfunction

  function automatic logic op_defined(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_ADDI) || (op == OP_ADD) ||
           (op == OP_HALT) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - clock-enable divider pacing the sequencer
// tick is high in the cycle the counter sits at DIV-1; tick_next says the following cycle will tick.
module tick_gen #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic tick_next
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  // During reset the counter restarts at zero, so the look-ahead must reflect that.
  assign tick_next = !rst_n ? (LAST == '0) : (count_d == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - FETCH/DECODE/EXEC/WB control FSM owning pc, ir and regfile strobes
// Optional SEQ_SINGLE_STEP_EN adds step_req: one rising edge runs exactly one instruction.
module proc_sequencer #(
  parameter int ADDR_W = 3,
  parameter int DIV    = 50000000,
  parameter int DIV_W  = 26
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_req,
`endif
  input  logic [15:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic              rf_we,
  output logic              wsel,
  output logic              out_we,
  output logic              illegal,
  output logic              halted,
  output logic [2:0]        state
);
  import proc_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              rf_we_q, rf_we_d, wsel_q, wsel_d, out_we_q, out_we_d;
  logic              illegal_q, illegal_d, halted_q, halted_d;
  logic              tick, tick_next, go;
  logic [3:0]        op_d;

  tick_gen #(.DIV(DIV), .DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .tick_next (tick_next)
  );

`ifdef SEQ_SINGLE_STEP_EN
  logic step_prev_q, pending_q, pending_d, consume;
  assign go      = pending_q;
  assign consume = tick && (state_q == ST_FETCH) && pending_q;
  // An edge arriving while one is consumed becomes the single pending request.
  assign pending_d = (step_req && !step_prev_q) || (pending_q && !consume);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      step_prev_q <= step_req;
      pending_q   <= pending_d;
    end
  end
`else
  assign go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wsel_d  = wsel_q;
    if (tick) begin
      case (state_q)
        ST_FETCH: begin
          if (go) begin
            ir_d    = instruction;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = ST_EXEC;
          wsel_d  = (f_op(ir_q) == OP_ADD);
        end
        ST_EXEC:  state_d = (f_op(ir_q) == OP_HALT) ? ST_HALT : ST_WB;
        ST_WB: begin
          pc_d    = pc_q + 1'b1;
          state_d = ST_FETCH;
        end
        default:  state_d = ST_HALT;
      endcase
    end
    // Strobes are registered, so they are armed one cycle ahead of the tick they belong to.
    op_d      = f_op(ir_d);
    rf_we_d   = tick_next && (state_d == ST_WB) && ((op_d == OP_ADDI) || (op_d == OP_ADD));
    out_we_d  = tick_next && (state_d == ST_WB) && (op_d == OP_OUT);
    illegal_d = tick_next && (state_d == ST_EXEC) && !op_defined(op_d);
    halted_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      rf_we_q   <= 1'b0;
      wsel_q    <= 1'b0;
      out_we_q  <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      rf_we_q   <= rf_we_d;
      wsel_q    <= wsel_d;
      out_we_q  <= out_we_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign rf_we   = rf_we_q;
  assign wsel    = wsel_q;
  assign out_we  = out_we_q;
  assign illegal = illegal_q;
  assign halted  = halted_q;
  assign state   = state_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - bench for proc_sequencer with regfile/ROM model, DIV=1 and DIV=3 instances
// Exercises the SEQ_SINGLE_STEP_EN build with its own sequence when that macro is defined.
module tb_proc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] rom1 [8];
  logic [15:0] rom3 [8];

  logic [2:0]  pc1, pc3;
  logic [15:0] ir1, ir3;
  logic        rf_we1, wsel1, out_we1, illegal1, halted1;
  logic        rf_we3, wsel3, out_we3, illegal3, halted3;
  logic [2:0]  state1, state3;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_req;
`endif

  proc_sequencer #(.ADDR_W(3), .DIV(1), .DIV_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .instruction(rom1[pc1]), .pc(pc1), .ir(ir1), .rf_we(rf_we1), .wsel(wsel1),
    .out_we(out_we1), .illegal(illegal1), .halted(halted1), .state(state1)
  );

  proc_sequencer #(.ADDR_W(3), .DIV(3), .DIV_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .instruction(rom3[pc3]), .pc(pc3), .ir(ir3), .rf_we(rf_we3), .wsel(wsel3),
    .out_we(out_we3), .illegal(illegal3), .halted(halted3), .state(state3)
  );

  logic [15:0] rf [8];
  logic [15:0] result;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
      result <= 16'h0;
    end else begin
      if (rf_we1)
        rf[ir1[11:9]] <= wsel1 ? rf[ir1[11:9]] + rf[ir1[8:6]] : {8'h00, ir1[7:0]};
      if (out_we1) result <= rf[ir1[11:9]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] instr;
    int we_cnt; int out_cnt; int ill_cnt; int strobe_cyc;
    int wsel_we; int pc_after; int halted_after; int r1_after;
  } vec_t;

  vec_t vecs [7];
  int we, oc, il, sc, ws, bad, cnt, pc_hold;

  initial begin
    rst_n = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      rom1[i] = 16'h0000;
      rom3[i] = 16'h0000;
    end

`ifndef SEQ_SINGLE_STEP_EN
    vecs[0] = '{16'h1205, 1, 0, 0, 3, 0, 1, 0, 5};
    vecs[1] = '{16'h0000, 0, 0, 0, -1, -1, 1, 0, 0};
    vecs[2] = '{16'h5123, 0, 0, 1, 2, -1, 1, 0, 0};
    vecs[3] = '{16'hE000, 0, 0, 0, -1, -1, 0, 1, 0};
    vecs[4] = '{16'hF200, 0, 1, 0, 3, -1, 1, 0, 0};
    vecs[5] = '{16'h2280, 1, 0, 0, 3, 1, 1, 0, 0};
    vecs[6] = '{16'h3000, 0, 0, 1, 2, -1, 1, 0, 0};

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 8; i++) rom1[i] = 16'h0000;
      rom1[0] = vecs[v].instr;
      do_reset();
      we = 0; oc = 0; il = 0; sc = -1; ws = -1;
      for (int c = 0; c < 4; c++) begin
        if (rf_we1) begin we++; ws = int'(wsel1); end
        if (out_we1) oc++;
        if (illegal1) il++;
        if ((rf_we1 || out_we1 || illegal1) && sc < 0) sc = c;
        @(negedge clk);
      end
      check($sformatf("vec%0d rf_we_count", v), we, vecs[v].we_cnt);
      check($sformatf("vec%0d out_we_count", v), oc, vecs[v].out_cnt);
      check($sformatf("vec%0d illegal_count", v), il, vecs[v].ill_cnt);
      check($sformatf("vec%0d strobe_cycle", v), sc, vecs[v].strobe_cyc);
      check($sformatf("vec%0d wsel_at_we", v), ws, vecs[v].wsel_we);
      check($sformatf("vec%0d pc_after", v), int'(pc1), vecs[v].pc_after);
      check($sformatf("vec%0d halted_after", v), int'(halted1), vecs[v].halted_after);
      check($sformatf("vec%0d r1_after", v), int'(rf[1]), vecs[v].r1_after);
    end

    // Reset from a non-zero state: all registers return to their reset values.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", int'(state1), 0);
    check("reset pc", int'(pc1), 0);
    check("reset ir", int'(ir1), 0);
    check("reset strobes", int'({rf_we1, wsel1, out_we1, illegal1, halted1}), 0);

    // ADDI r1,3; ADDI r2,4; ADD r1=r1+r2; OUT r1
    rom1[0] = 16'h1203; rom1[1] = 16'h1404; rom1[2] = 16'h2280; rom1[3] = 16'hF200;
    for (int i = 4; i < 8; i++) rom1[i] = 16'h0000;
    do_reset();
    we = 0; oc = 0;
    for (int c = 0; c < 16; c++) begin
      if (rf_we1) we++;
      if (out_we1) oc++;
      @(negedge clk);
    end
    check("prog rf_we_count", we, 3);
    check("prog out_we_count", oc, 1);
    check("prog r2", int'(rf[2]), 4);
    check("prog result", int'(result), 7);
    check("prog pc", int'(pc1), 4);

    // Eight NOPs: pc walks 0..7 and wraps, no strobes.
    for (int i = 0; i < 8; i++) rom1[i] = 16'h0000;
    do_reset();
    bad = 0; cnt = 0;
    for (int c = 0; c < 32; c++) begin
      if (int'(pc1) != (c / 4) % 8) bad++;
      if (rf_we1 || out_we1) cnt++;
      @(negedge clk);
    end
    check("nop pc sequence errors", bad, 0);
    check("nop strobes", cnt, 0);
    check("nop pc wrap", int'(pc1), 0);

    // HALT absorbs for 100 clocks.
    rom1[0] = 16'hE000;
    for (int i = 1; i < 8; i++) rom1[i] = 16'h1205;
    do_reset();
    repeat (4) @(negedge clk);
    check("halt halted", int'(halted1), 1);
    pc_hold = int'(pc1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (int'(pc1) != 0 || state1 != 3'd4 || !halted1 || rf_we1 || out_we1) bad++;
      @(negedge clk);
    end
    check("halt frozen violations", bad, 0);
    check("halt pc", pc_hold, 0);

    // DIV=3: strobe only on tick cycles (counter==2 -> cycles 2,5,8,11), 12 clks per instruction.
    rom3[0] = 16'h1205;
    do_reset();
    we = 0; sc = -1; bad = 0; ws = -1;
    for (int c = 0; c <= 12; c++) begin
      if (rf_we3) begin
        we++;
        ws = int'(wsel3);
        if (sc < 0) sc = c;
        if (c % 3 != 2) bad++;
      end
      if (c == 2) check("div3 state c2", int'(state3), 0);
      if (c == 3) check("div3 state c3", int'(state3), 1);
      if (c == 11) check("div3 pc c11", int'(pc3), 0);
      if (c == 12) check("div3 pc c12", int'(pc3), 1);
      @(negedge clk);
    end
    check("div3 rf_we_count", we, 1);
    check("div3 rf_we_cycle", sc, 11);
    check("div3 off-tick strobes", bad, 0);
    check("div3 wsel", ws, 0);

    // Reset asserted while ADDI sits in EXEC.
    rom1[0] = 16'h1205;
    for (int i = 1; i < 8; i++) rom1[i] = 16'h0000;
    do_reset();
    repeat (2) @(negedge clk);
    check("rst_exec state before", int'(state1), 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_exec state", int'(state1), 0);
    check("rst_exec pc", int'(pc1), 0);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (rf_we1) cnt++;
      @(negedge clk);
    end
    check("rst_exec no rf_we", cnt, 0);
    rst_n = 1'b1;
`else
    rom1[0] = 16'h1205;
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (pc1 != 3'd0 || state1 != 3'd0 || rf_we1) bad++;
      @(negedge clk);
    end
    check("step idle violations", bad, 0);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    we = 0;
    for (int c = 0; c < 12; c++) begin
      if (rf_we1) we++;
      @(negedge clk);
    end
    check("step rf_we_count", we, 1);
    check("step pc", int'(pc1), 1);
    check("step r1", int'(rf[1]), 5);
    repeat (10) @(negedge clk);
    check("step pc stays", int'(pc1), 1);
    check("step state fetch", int'(state1), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
